fp_align_stage: RTL and testbench

FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

---
 rtl/fp_pkg.sv | 65 ++++++
 rtl/fp_align_stage_if.sv | 37 +++
 rtl/fp_sticky_shifter.sv | 36 +++
 rtl/fp_align_stage.sv | 119 +++++++++++
 tb/tb_fp_align_stage.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point alignment stage and the
// downstream adder stage. The optional macro FP_ALIGN_DENORM_EN selects
// subnormal support (defined) or flush-to-zero of subnormals (undefined).
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int GRS_W  = 3;
    localparam int SIG_W  = MAN_W + 1;
    localparam int ALN_W  = SIG_W + GRS_W;
    localparam int WORD_W = 1 + EXP_W + MAN_W;

    // One operand after classification: hidden bit, effective exponent, fraction.
    typedef struct packed {
        logic             hidden;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } operand_t;

    // Stage-1 register contents: operands ordered by magnitude, shift pending.
    typedef struct packed {
        logic              sign_l;
        logic              sign_s;
        logic              eff_sub;
        logic [EXP_W-1:0]  exp_l;
        logic [EXP_W-1:0]  shamt;
        logic [SIG_W-1:0]  sig_l;
        logic [SIG_W-1:0]  sig_s;
        logic              spl_case;
        logic [WORD_W-1:0] spl_result;
    } cmp_pair_t;

    // Aligned pair handed to the adder stage.
    typedef struct packed {
        logic              sign_l;
        logic              sign_s;
        logic              eff_sub;
        logic [EXP_W-1:0]  exp;
        logic [SIG_W-1:0]  mant_l;
        logic [ALN_W-1:0]  mant_s;
        logic              spl_case;
        logic [WORD_W-1:0] spl_result;
    } aligned_pair_t;

    // Split a single-precision word into hidden bit, effective exponent and fraction.
    function automatic operand_t classify(input logic [WORD_W-1:0] w);
        operand_t         op;
        logic [EXP_W-1:0] e;
        e         = w[WORD_W-2 -: EXP_W];
        op.hidden = |e;
        op.frac   = w[MAN_W-1:0];
`ifdef FP_ALIGN_DENORM_EN
        // Subnormals keep their fraction and sit at exponent 1.
        op.exp    = (e == '0) ? EXP_W'(1) : e;
`else
        // Subnormals are flushed to zero magnitude; the sign lives elsewhere.
        op.exp    = e;
        if (!op.hidden) begin
            op.frac = '0;
        end
`endif
        return op;
    endfunction

endpackage

// File: rtl/fp_align_stage_if.sv
// Handshake and data bundle of the alignment stage. The stage uses the slave
// modport (consumes operands, produces the aligned pair); the environment
// uses the master modport.
interface fp_align_stage_if;
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              spl_case_in;
    logic [WORD_W-1:0] spl_result_in;

    logic              out_valid;
    logic              out_ready;
    logic              out_spl_case;
    logic [WORD_W-1:0] out_spl_result;
    logic              out_sign_l;
    logic              out_sign_s;
    logic              out_eff_sub;
    logic [EXP_W-1:0]  out_exp;
    logic [SIG_W-1:0]  out_mant_l;
    logic [ALN_W-1:0]  out_mant_s;

    modport slave (
        input  in_valid, a, b, spl_case_in, spl_result_in, out_ready,
        output in_ready, out_valid, out_spl_case, out_spl_result,
               out_sign_l, out_sign_s, out_eff_sub, out_exp, out_mant_l, out_mant_s
    );

    modport master (
        output in_valid, a, b, spl_case_in, spl_result_in, out_ready,
        input  in_ready, out_valid, out_spl_case, out_spl_result,
               out_sign_l, out_sign_s, out_eff_sub, out_exp, out_mant_l, out_mant_s
    );

endinterface

// File: rtl/fp_sticky_shifter.sv
// Combinational right shift of the smaller significand with sticky collapse:
// every bit shifted past the LSB is ORed into the LSB (the S position).
// Shifts of W or more collapse the whole input into the sticky bit.
module fp_sticky_shifter
    import fp_pkg::*;
#(
    parameter int W    = ALN_W,
    parameter int SH_W = EXP_W
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] shamt,
    output logic [W-1:0]    dout
);

    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;
    logic         sticky;

    // Shift, then fold the discarded bits into the LSB.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        shifted   = '0;
        lost_mask = '0;
        sticky    = 1'b0;
        dout      = '0;
        if (shamt >= SH_W'(W)) begin
            dout = {{(W-1){1'b0}}, |din};
        end else begin
            shifted   = din >> shamt;
            lost_mask = ~({W{1'b1}} << shamt);
            sticky    = |(din & lost_mask);
            dout      = {shifted[W-1:1], shifted[0] | sticky};
        end
    end

endmodule

// File: rtl/fp_align_stage.sv
// Two-register alignment stage ahead of the FP adder. Stage 1 classifies both
// operands, compares magnitudes and swaps so the larger comes first; stage 2
// right-shifts the smaller significand by the exponent difference with sticky.
// Elastic valid/ready chain, latency 2, one pair per cycle. Subnormal handling
// is selected by the macro FP_ALIGN_DENORM_EN (see fp_pkg::classify).
module fp_align_stage #(
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int MAN_W = fp_pkg::MAN_W
) (
    input  logic           clk,
    input  logic           rst,
    fp_align_stage_if.slave io
);

    localparam int ALN_W = MAN_W + 1 + fp_pkg::GRS_W;
    localparam int WW    = fp_pkg::WORD_W;

    fp_pkg::cmp_pair_t     s1_d, s1_q;
    fp_pkg::aligned_pair_t s2_d, s2_q;
    logic                  v1_d, v1_q;
    logic                  v2_d, v2_q;
    logic                  r1, r2;

    fp_pkg::operand_t      op_a, op_b, op_l, op_s;
    logic                  a_larger;
    logic [ALN_W-1:0]      mant_s_aligned;

    // Ready chain: a stage can load when empty or when its successor takes its content.
    always_comb begin
        r2 = !v2_q || io.out_ready;
        r1 = !v1_q || r2;
    end

    assign io.in_ready  = r1 && !rst;
    assign io.out_valid = v2_q && !rst;

    // Stage 1 next state: classify, compare magnitudes (a wins ties), order the pair.
    always_comb begin
        op_a     = fp_pkg::classify(io.a);
        op_b     = fp_pkg::classify(io.b);
        a_larger = io.a[WW-2:0] >= io.b[WW-2:0];
        op_l     = a_larger ? op_a : op_b;
        op_s     = a_larger ? op_b : op_a;
        s1_d     = s1_q;
        v1_d     = v1_q;
        if (r1) begin
            v1_d = io.in_valid;
            if (io.in_valid) begin
                s1_d            = '0;
                s1_d.spl_case   = io.spl_case_in;
                s1_d.spl_result = io.spl_result_in;
                if (!io.spl_case_in) begin
                    s1_d.sign_l  = a_larger ? io.a[WW-1] : io.b[WW-1];
                    s1_d.sign_s  = a_larger ? io.b[WW-1] : io.a[WW-1];
                    s1_d.eff_sub = io.a[WW-1] ^ io.b[WW-1];
                    s1_d.exp_l   = op_l.exp;
                    s1_d.shamt   = op_l.exp - op_s.exp;
                    s1_d.sig_l   = {op_l.hidden, op_l.frac};
                    s1_d.sig_s   = {op_s.hidden, op_s.frac};
                end
            end
        end
    end

    fp_sticky_shifter #(
        .W    (ALN_W),
        .SH_W (EXP_W)
    ) u_shifter (
        .din   ({s1_q.sig_s, {fp_pkg::GRS_W{1'b0}}}),
        .shamt (s1_q.shamt),
        .dout  (mant_s_aligned)
    );

    // Stage 2 next state: capture the shifted smaller significand.
    always_comb begin
        s2_d = s2_q;
        v2_d = v2_q;
        if (r2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_d.sign_l     = s1_q.sign_l;
                s2_d.sign_s     = s1_q.sign_s;
                s2_d.eff_sub    = s1_q.eff_sub;
                s2_d.exp        = s1_q.exp_l;
                s2_d.mant_l     = s1_q.sig_l;
                s2_d.mant_s     = mant_s_aligned;
                s2_d.spl_case   = s1_q.spl_case;
                s2_d.spl_result = s1_q.spl_result;
            end
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            // NOTE: data registers are reset as well so the outputs read 0 after reset.
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign io.out_spl_case   = s2_q.spl_case;
    assign io.out_spl_result = s2_q.spl_result;
    assign io.out_sign_l     = s2_q.sign_l;
    assign io.out_sign_s     = s2_q.sign_s;
    assign io.out_eff_sub    = s2_q.eff_sub;
    assign io.out_exp        = s2_q.exp;
    assign io.out_mant_l     = s2_q.mant_l;
    assign io.out_mant_s     = s2_q.mant_s;

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed self-checking bench for fp_align_stage. Inputs change 1 ns after
// the rising edge; outputs are sampled a further 1 ns later.
module tb_fp_align_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fp_align_stage_if io ();

    fp_align_stage dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair with downstream always ready; leaves the pair on the outputs.
    task automatic run_pair(input logic [31:0] ta, input logic [31:0] tbv,
                            input logic spl, input logic [31:0] sres);
        io.out_ready     = 1'b1;
        io.in_valid      = 1'b1;
        io.a             = ta;
        io.b             = tbv;
        io.spl_case_in   = spl;
        io.spl_result_in = sres;
        #1;
        check("in_ready_before_accept", {31'd0, io.in_ready}, 32'd1);
        step();
        io.in_valid = 1'b0;
        #1;
        check("latency_not_1", {31'd0, io.out_valid}, 32'd0);
        step();
        #1;
        check("latency_2_valid", {31'd0, io.out_valid}, 32'd1);
    endtask

    task automatic check_fields(input string tag, input logic [7:0] e, input logic [23:0] ml,
                                input logic [26:0] ms, input logic sl, input logic ss,
                                input logic es);
        check({tag, "_exp"},     {24'd0, io.out_exp},     {24'd0, e});
        check({tag, "_mant_l"},  {8'd0, io.out_mant_l},   {8'd0, ml});
        check({tag, "_mant_s"},  {5'd0, io.out_mant_s},   {5'd0, ms});
        check({tag, "_sign_l"},  {31'd0, io.out_sign_l},  {31'd0, sl});
        check({tag, "_sign_s"},  {31'd0, io.out_sign_s},  {31'd0, ss});
        check({tag, "_eff_sub"}, {31'd0, io.out_eff_sub}, {31'd0, es});
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        io.in_valid      = 1'b1;
        io.out_ready     = 1'b1;
        io.a             = 32'h3F80_0000;
        io.b             = 32'h4000_0000;
        io.spl_case_in   = 1'b0;
        io.spl_result_in = 32'h0;

        // Reset: handshake outputs low even with a valid offer pending.
        step();
        step();
        check("rst_in_ready",  {31'd0, io.in_ready},  32'd0);
        check("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        io.in_valid = 1'b0;
        rst         = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, io.in_ready}, 32'd1);
        check("post_rst_spl_result", io.out_spl_result, 32'h0);
        check_fields("post_rst", 8'h00, 24'h0, 27'h0, 1'b0, 1'b0, 1'b0);

        // 1.0 + 2.0: b larger, d = 1.
        run_pair(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h0);
        check_fields("one_two", 8'h80, 24'h80_0000, 27'h200_0000, 1'b0, 1'b0, 1'b0);

        // d = 24: G and S both set.
        run_pair(32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h0);
        check_fields("d24", 8'h7F, 24'h80_0000, 27'h000_0005, 1'b0, 1'b0, 1'b0);

        // d = 28: full collapse to sticky, opposite signs.
        run_pair(32'h4D80_0000, 32'hBF80_0000, 1'b0, 32'h0);
        check_fields("d28", 8'h9B, 24'h80_0000, 27'h000_0001, 1'b0, 1'b1, 1'b1);

        // Equal magnitudes: a taken as larger, so sign_l comes from a.
        run_pair(32'h4040_0000, 32'hC040_0000, 1'b0, 32'h0);
        check_fields("tie", 8'h80, 24'hC0_0000, 27'h600_0000, 1'b0, 1'b1, 1'b1);

        // Smaller operand on a with negative sign: swap carries signs along.
        run_pair(32'hBF80_0000, 32'h4080_0000, 1'b0, 32'h0);
        check_fields("swap", 8'h81, 24'h80_0000, 27'h100_0000, 1'b0, 1'b1, 1'b1);

        // Special case: flag and result pass through, datapath fields forced to 0.
        run_pair(32'hC0A0_0000, 32'h3F80_0000, 1'b1, 32'h7FC0_0000);
        check("spl_flag",   {31'd0, io.out_spl_case}, 32'd1);
        check("spl_result", io.out_spl_result, 32'h7FC0_0000);
        check_fields("spl", 8'h00, 24'h0, 27'h0, 1'b0, 1'b0, 1'b0);

        // Two subnormals.
        run_pair(32'h0000_0002, 32'h0000_0001, 1'b0, 32'h0);
`ifdef FP_ALIGN_DENORM_EN
        check_fields("denorm", 8'h01, 24'h00_0002, 27'h000_0008, 1'b0, 1'b0, 1'b0);
`else
        check_fields("denorm", 8'h00, 24'h00_0000, 27'h000_0000, 1'b0, 1'b0, 1'b0);
`endif
        check("denorm_spl_flag", {31'd0, io.out_spl_case}, 32'd0);

        // Backpressure: three back-to-back offers, downstream stalled.
        step();
        io.out_ready = 1'b0;
        io.in_valid  = 1'b1;
        io.a         = 32'h3F80_0000;   // P0: exp 7F, d 0
        io.b         = 32'h3F80_0000;
        step();
        io.a         = 32'h4000_0000;   // P1: exp 80, d 1
        #1;
        check("bp_ready_after_1", {31'd0, io.in_ready}, 32'd1);
        step();
        io.a         = 32'h4080_0000;   // P2: exp 81, d 2
        #1;
        check("bp_ready_after_2", {31'd0, io.in_ready}, 32'd0);
        check("bp_p0_valid", {31'd0, io.out_valid}, 32'd1);
        step();
        step();
        #1;
        check("bp_hold_valid", {31'd0, io.out_valid}, 32'd1);
        check("bp_hold_exp",   {24'd0, io.out_exp}, 32'h7F);
        check("bp_hold_mant_s", {5'd0, io.out_mant_s}, 32'h400_0000);
        check("bp_hold_ready", {31'd0, io.in_ready}, 32'd0);
        io.out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, io.in_ready}, 32'd1);
        step();
        io.in_valid = 1'b0;
        #1;
        check("bp_p1_valid",  {31'd0, io.out_valid}, 32'd1);
        check("bp_p1_exp",    {24'd0, io.out_exp}, 32'h80);
        check("bp_p1_mant_s", {5'd0, io.out_mant_s}, 32'h200_0000);
        step();
        #1;
        check("bp_p2_valid",  {31'd0, io.out_valid}, 32'd1);
        check("bp_p2_exp",    {24'd0, io.out_exp}, 32'h81);
        check("bp_p2_mant_s", {5'd0, io.out_mant_s}, 32'h100_0000);
        step();
        #1;
        check("bp_drained", {31'd0, io.out_valid}, 32'd0);

        // Reset mid-operation discards the in-flight pair.
        io.in_valid = 1'b1;
        io.a        = 32'h4000_0000;
        io.b        = 32'h3F80_0000;
        step();
        io.in_valid = 1'b0;
        rst         = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, io.out_valid}, 32'd0);
        check("midrst_in_ready",  {31'd0, io.in_ready},  32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        #1;
        check("midrst_no_output", {31'd0, io.out_valid}, 32'd0);
        check("midrst_exp_zero",  {24'd0, io.out_exp}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
